id_ex_stage: RTL and testbench

- Decode-to-execute pipeline boundary sitting directly downstream of the register file.
- Captures rdata1/rdata2 together with decode control and resolves operand forwarding from the EX, MEM and WB stages at capture time.
- Detects load-use hazards, inserts bubbles, and honours execute-busy holds and branch flushes.
- Keeps 32-bit stall and flush event counters for performance monitoring.

---
 rtl/core_pkg.sv | 17 +
 rtl/operand_forward.sv | 47 ++++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the decode/execute boundary.
//   XLEN     - datapath width
//   CTRL_W   - width of the opaque decoded control bundle
//   REG_X0   - index of the hard-wired zero register
//   fwd_sel_e- which pipeline point supplied an operand
package core_pkg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;
endpackage

// File: rtl/operand_forward.sv
// Combinational operand bypass for one source register.
// Ports:
//   i_rs                   source register index
//   i_rdata                register file read data for i_rs
//   i_ex_en/i_ex_rd/i_ex_data     EX producer (enable already qualified)
//   i_mem_en/i_mem_rd/i_mem_data  MEM producer (enable already qualified)
//   i_wb_en/i_wb_rd/i_wb_data     WB producer
//   o_operand              selected operand value
//   o_sel                  source of o_operand
module operand_forward #(
  parameter int W = core_pkg::XLEN
) (
  input  logic [4:0]         i_rs,
  input  logic [W-1:0]       i_rdata,
  input  logic               i_ex_en,
  input  logic [4:0]         i_ex_rd,
  input  logic [W-1:0]       i_ex_data,
  input  logic               i_mem_en,
  input  logic [4:0]         i_mem_rd,
  input  logic [W-1:0]       i_mem_data,
  input  logic               i_wb_en,
  input  logic [4:0]         i_wb_rd,
  input  logic [W-1:0]       i_wb_data,
  output logic [W-1:0]       o_operand,
  output core_pkg::fwd_sel_e o_sel
);
  import core_pkg::*;

  // Youngest producer wins; x0 is never bypassed and always reads zero.
  always_comb begin
    o_sel     = FWD_RF;
    o_operand = i_rdata;
    if (i_rs == REG_X0) begin
      o_sel     = FWD_RF;
      o_operand = '0;
    end else if (i_ex_en && (i_ex_rd == i_rs)) begin
      o_sel     = FWD_EX;
      o_operand = i_ex_data;
    end else if (i_mem_en && (i_mem_rd == i_rs)) begin
      o_sel     = FWD_MEM;
      o_operand = i_mem_data;
    end else if (i_wb_en && (i_wb_rd == i_rs)) begin
      o_sel     = FWD_WB;
      o_operand = i_wb_data;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use
// hazard detection, execute-busy hold, branch flush and event counters.
// Ports:
//   clk, rst                    clock, async active-high reset
//   *_D                         decode-stage instruction fields
//   rdata1, rdata2              register file read data
//   alu_result_E                ALU output of the instruction in EX
//   rd_M/regwr_M/memrd_M/alu_result_M   MEM stage producer
//   waddr_W/reg_wrW/wdata_W     WB stage producer
//   ex_busy, flush              hold / kill requests
//   stall_D                     hold fetch/decode this cycle
//   *_E, op1_E, op2_E           registered instruction entering EX
//   stall_cnt, flush_cnt        wrapping event counters
module id_ex_stage #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_D,
  input  logic [XLEN-1:0]   pc_D,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [4:0]        rd_D,
  input  logic              regwr_D,
  input  logic              memrd_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [XLEN-1:0]   rdata1,
  input  logic [XLEN-1:0]   rdata2,
  input  logic [XLEN-1:0]   alu_result_E,
  input  logic [4:0]        rd_M,
  input  logic              regwr_M,
  input  logic              memrd_M,
  input  logic [XLEN-1:0]   alu_result_M,
  input  logic [4:0]        waddr_W,
  input  logic              reg_wrW,
  input  logic [XLEN-1:0]   wdata_W,
  input  logic              ex_busy,
  input  logic              flush,
  output logic              stall_D,
  output logic              valid_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [4:0]        rs1_E,
  output logic [4:0]        rs2_E,
  output logic [4:0]        rd_E,
  output logic              regwr_E,
  output logic              memrd_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [XLEN-1:0]   op1_E,
  output logic [XLEN-1:0]   op2_E,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import core_pkg::*;

  logic      w_ex_fwd_en;
  logic      w_mem_fwd_en;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  fwd_sel_e  w_fwd_sel1;
  fwd_sel_e  w_fwd_sel2;
  logic      w_unused_fwd_sel;
  logic      w_luh_ex;
  logic      w_luh_mem;
  logic      w_luh;

  // A load in EX or MEM has only an address, so it cannot be bypassed.
  assign w_ex_fwd_en  = valid_E && regwr_E && !memrd_E;
  assign w_mem_fwd_en = regwr_M && !memrd_M;

  operand_forward #(.W(XLEN)) u_fwd1 (
    .i_rs(rs1_D), .i_rdata(rdata1),
    .i_ex_en(w_ex_fwd_en), .i_ex_rd(rd_E), .i_ex_data(alu_result_E),
    .i_mem_en(w_mem_fwd_en), .i_mem_rd(rd_M), .i_mem_data(alu_result_M),
    .i_wb_en(reg_wrW), .i_wb_rd(waddr_W), .i_wb_data(wdata_W),
    .o_operand(w_op1), .o_sel(w_fwd_sel1)
  );

  operand_forward #(.W(XLEN)) u_fwd2 (
    .i_rs(rs2_D), .i_rdata(rdata2),
    .i_ex_en(w_ex_fwd_en), .i_ex_rd(rd_E), .i_ex_data(alu_result_E),
    .i_mem_en(w_mem_fwd_en), .i_mem_rd(rd_M), .i_mem_data(alu_result_M),
    .i_wb_en(reg_wrW), .i_wb_rd(waddr_W), .i_wb_data(wdata_W),
    .o_operand(w_op2), .o_sel(w_fwd_sel2)
  );

  // Forwarding source is kept only for debug visibility in waveforms.
  assign w_unused_fwd_sel = ^{w_fwd_sel1, w_fwd_sel2};

  // Load data becomes forwardable only from WB, so a load in EX or MEM
  // feeding this instruction forces a bubble.
  assign w_luh_ex  = valid_E && memrd_E && (rd_E != REG_X0) &&
                     ((use_rs1_D && (rs1_D == rd_E)) ||
                      (use_rs2_D && (rs2_D == rd_E)));
  assign w_luh_mem = memrd_M && (rd_M != REG_X0) &&
                     ((use_rs1_D && (rs1_D == rd_M)) ||
                      (use_rs2_D && (rs2_D == rd_M)));
  assign w_luh     = valid_D && (w_luh_ex || w_luh_mem);

  assign stall_D = !rst && (ex_busy || w_luh);

  // ID/EX boundary: flush > busy hold > load-use bubble > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_E   <= 1'b0;
      pc_E      <= '0;
      rs1_E     <= '0;
      rs2_E     <= '0;
      rd_E      <= '0;
      regwr_E   <= 1'b0;
      memrd_E   <= 1'b0;
      imm_E     <= '0;
      ctrl_E    <= '0;
      op1_E     <= '0;
      op2_E     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush || (!ex_busy && w_luh)) begin
        valid_E <= 1'b0;
        regwr_E <= 1'b0;
        memrd_E <= 1'b0;
      end else if (!ex_busy) begin
        valid_E <= valid_D;
        pc_E    <= pc_D;
        rs1_E   <= rs1_D;
        rs2_E   <= rs2_D;
        rd_E    <= rd_D;
        regwr_E <= regwr_D;
        memrd_E <= memrd_D;
        imm_E   <= imm_D;
        ctrl_E  <= ctrl_D;
        op1_E   <= w_op1;
        op2_E   <= w_op2;
      end
      if (stall_D && !flush)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XL = 32;
  localparam int CW = 12;
  localparam int CN = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_D, use_rs1_D, use_rs2_D, regwr_D, memrd_D;
  logic [XL-1:0] pc_D, imm_D, rdata1, rdata2, alu_result_E, alu_result_M, wdata_W;
  logic [4:0]    rs1_D, rs2_D, rd_D, rd_M, waddr_W;
  logic [CW-1:0] ctrl_D;
  logic          regwr_M, memrd_M, reg_wrW, ex_busy, flush;
  logic          stall_D, valid_E, regwr_E, memrd_E;
  logic [XL-1:0] pc_E, imm_E, op1_E, op2_E;
  logic [4:0]    rs1_E, rs2_E, rd_E;
  logic [CW-1:0] ctrl_E;
  logic [CN-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XL), .CTRL_W(CW), .CNT_W(CN)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .pc_D(pc_D), .rs1_D(rs1_D),
    .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_D(rd_D),
    .regwr_D(regwr_D), .memrd_D(memrd_D), .imm_D(imm_D), .ctrl_D(ctrl_D),
    .rdata1(rdata1), .rdata2(rdata2), .alu_result_E(alu_result_E),
    .rd_M(rd_M), .regwr_M(regwr_M), .memrd_M(memrd_M),
    .alu_result_M(alu_result_M), .waddr_W(waddr_W), .reg_wrW(reg_wrW),
    .wdata_W(wdata_W), .ex_busy(ex_busy), .flush(flush), .stall_D(stall_D),
    .valid_E(valid_E), .pc_E(pc_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .regwr_E(regwr_E), .memrd_E(memrd_E), .imm_E(imm_E),
    .ctrl_E(ctrl_E), .op1_E(op1_E), .op2_E(op2_E), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the instruction currently sitting in EX.
  logic          m_valid, m_regwr, m_memrd;
  logic [4:0]    m_rs1, m_rs2, m_rd;
  logic [XL-1:0] m_pc, m_imm, m_op1, m_op2;
  logic [CW-1:0] m_ctrl;
  logic [CN-1:0] m_scnt, m_fcnt;

  task automatic model_reset();
    m_valid = 0; m_regwr = 0; m_memrd = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic logic [XL-1:0] model_operand(input logic [4:0] rs, input logic [XL-1:0] rf);
    if (rs == 5'd0) return '0;
    if (m_valid && m_regwr && !m_memrd && m_rd == rs) return alu_result_E;
    if (regwr_M && !memrd_M && rd_M == rs) return alu_result_M;
    if (reg_wrW && waddr_W == rs) return wdata_W;
    return rf;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (use_rs1_D && rs1_D == r) || (use_rs2_D && rs2_D == r);
  endfunction

  function automatic bit model_luh();
    bit in_ex, in_mem;
    in_ex  = m_valid && m_memrd && m_rd != 5'd0 && reads(m_rd);
    in_mem = memrd_M && rd_M != 5'd0 && reads(rd_M);
    return valid_D && (in_ex || in_mem);
  endfunction

  task automatic clr_in();
    valid_D = 0; pc_D = 0; rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0;
    rd_D = 0; regwr_D = 0; memrd_D = 0; imm_D = 0; ctrl_D = 0;
    rdata1 = 0; rdata2 = 0; alu_result_E = 0; rd_M = 0; regwr_M = 0;
    memrd_M = 0; alu_result_M = 0; waddr_W = 0; reg_wrW = 0; wdata_W = 0;
    ex_busy = 0; flush = 0;
  endtask

  // One clock: check combinational stall, advance the model, check E state.
  task automatic cyc();
    bit luh, exp_stall;
    logic [XL-1:0] o1, o2;
    #1;
    luh       = model_luh();
    exp_stall = ex_busy || luh;
    check("stall_D", stall_D, exp_stall);
    o1 = model_operand(rs1_D, rdata1);
    o2 = model_operand(rs2_D, rdata2);
    if (exp_stall && !flush) m_scnt = m_scnt + 1;
    if (flush) m_fcnt = m_fcnt + 1;
    if (flush || (!ex_busy && luh)) begin
      m_valid = 0; m_regwr = 0; m_memrd = 0;
    end else if (!ex_busy) begin
      m_valid = valid_D; m_pc = pc_D; m_rs1 = rs1_D; m_rs2 = rs2_D;
      m_rd = rd_D; m_regwr = regwr_D; m_memrd = memrd_D; m_imm = imm_D;
      m_ctrl = ctrl_D; m_op1 = o1; m_op2 = o2;
    end
    @(posedge clk);
    #1;
    check("valid_E", valid_E, m_valid);
    check("ctl_E", {regwr_E, memrd_E, rd_E, rs1_E, rs2_E}, {m_regwr, m_memrd, m_rd, m_rs1, m_rs2});
    check("pc_E", pc_E, m_pc);
    check("imm_E", imm_E, m_imm);
    check("ctrl_E", ctrl_E, m_ctrl);
    check("op1_E", op1_E, m_op1);
    check("op2_E", op2_E, m_op2);
    check("stall_cnt", stall_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
  endtask

  logic [CN-1:0] s_base, f_base;

  initial begin
    clr_in();
    model_reset();
    rst = 1;
    #12 rst = 0;
    check("rst_valid", valid_E, 1'b0);
    check("rst_ctl", {regwr_E, memrd_E, stall_D}, 3'b000);
    check("rst_cnt", {stall_cnt, flush_cnt}, 64'd0);
    check("rst_ops", {op1_E, op2_E}, 64'd0);

    // Independent instruction
    valid_D = 1; pc_D = 32'h100; rs1_D = 3; rs2_D = 4; use_rs1_D = 1; use_rs2_D = 1;
    rdata1 = 32'h11; rdata2 = 32'h22; rd_D = 6; imm_D = 32'h5; ctrl_D = 12'hABC;
    #1 check("indep_stall", stall_D, 1'b0);
    cyc();
    check("indep_op1", op1_E, 32'h11);
    check("indep_op2", op2_E, 32'h22);
    check("indep_valid", valid_E, 1'b1);

    // EX forward beats MEM and WB
    clr_in(); valid_D = 1; rd_D = 5; regwr_D = 1; pc_D = 32'h104;
    cyc();
    clr_in(); valid_D = 1; rs1_D = 5; use_rs1_D = 1; rd_D = 0; regwr_D = 1; pc_D = 32'h108;
    alu_result_E = 32'hAA; rd_M = 5; regwr_M = 1; alu_result_M = 32'hBB;
    waddr_W = 5; reg_wrW = 1; wdata_W = 32'hCC; rdata1 = 32'hDD;
    cyc();
    check("exfwd_op1", op1_E, 32'hAA);

    // x0 never forwards
    clr_in(); valid_D = 1; rs1_D = 0; use_rs1_D = 1; pc_D = 32'h10C;
    alu_result_E = 32'hFF; rd_M = 0; regwr_M = 1; alu_result_M = 32'hFF;
    waddr_W = 0; reg_wrW = 1; wdata_W = 32'hFF; rdata1 = 32'hFF;
    cyc();
    check("x0_op1", op1_E, 32'h0);

    // Load-use from EX, then from MEM, then WB forward
    clr_in(); valid_D = 1; rd_D = 7; regwr_D = 1; memrd_D = 1; pc_D = 32'h110;
    cyc();
    clr_in(); valid_D = 1; rs2_D = 7; use_rs2_D = 1; rs1_D = 1; rd_D = 8; regwr_D = 1;
    pc_D = 32'h400; rdata2 = 32'h5555;
    s_base = m_scnt;
    #1 check("luh_ex_stall", stall_D, 1'b1);
    cyc();
    check("luh_ex_bubble", valid_E, 1'b0);
    rd_M = 7; regwr_M = 1; memrd_M = 1; alu_result_M = 32'hDEAD;
    #1 check("luh_mem_stall", stall_D, 1'b1);
    cyc();
    check("luh_mem_bubble", valid_E, 1'b0);
    rd_M = 0; regwr_M = 0; memrd_M = 0; waddr_W = 7; reg_wrW = 1; wdata_W = 32'h1234;
    #1 check("wb_stall", stall_D, 1'b0);
    cyc();
    check("wb_op2", op2_E, 32'h1234);
    check("wb_valid", valid_E, 1'b1);
    check("luh_scnt", stall_cnt, s_base + 2);

    // ex_busy hold for 3 cycles
    ex_busy = 1; pc_D = 32'h999; rdata2 = $urandom; wdata_W = 32'h4321;
    s_base = m_scnt;
    for (int i = 0; i < 3; i++) begin
      #1 check("busy_stall", stall_D, 1'b1);
      cyc();
      check("busy_pc", pc_E, 32'h400);
      check("busy_op2", op2_E, 32'h1234);
      check("busy_valid", valid_E, 1'b1);
    end
    check("busy_scnt", stall_cnt, s_base + 3);

    // Flush together with a load-use hazard
    clr_in(); valid_D = 1; rd_D = 9; regwr_D = 1; memrd_D = 1; pc_D = 32'h500;
    cyc();
    clr_in(); valid_D = 1; rs1_D = 9; use_rs1_D = 1; flush = 1; pc_D = 32'h504;
    s_base = m_scnt; f_base = m_fcnt;
    #1 check("fl_stall", stall_D, 1'b1);
    cyc();
    check("fl_valid", valid_E, 1'b0);
    check("fl_fcnt", flush_cnt, f_base + 1);
    check("fl_scnt", stall_cnt, s_base);

    // Reset asserted in the middle of a busy hold
    clr_in(); valid_D = 1; rs1_D = 2; use_rs1_D = 1; rdata1 = 32'h77; pc_D = 32'h600;
    cyc();
    ex_busy = 1;
    cyc();
    #2 rst = 1;
    #1;
    check("mrst_valid", valid_E, 1'b0);
    check("mrst_stall", stall_D, 1'b0);
    check("mrst_regs", {pc_E, op1_E}, 64'd0);
    check("mrst_cnt", {stall_cnt, flush_cnt}, 64'd0);
    #1 rst = 0;
    model_reset();
    ex_busy = 0; pc_D = 32'h700; rdata1 = 32'h88;
    cyc();
    check("post_rst_op1", op1_E, 32'h88);
    check("post_rst_pc", pc_E, 32'h700);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      valid_D = $urandom_range(0, 3) != 0;
      pc_D = $urandom; imm_D = $urandom; ctrl_D = CW'($urandom);
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      use_rs1_D = $urandom_range(0, 1); use_rs2_D = $urandom_range(0, 1);
      rd_D = 5'($urandom_range(0, 3)); regwr_D = $urandom_range(0, 1);
      memrd_D = $urandom_range(0, 3) == 0;
      rdata1 = $urandom; rdata2 = $urandom;
      alu_result_E = $urandom; alu_result_M = $urandom; wdata_W = $urandom;
      rd_M = 5'($urandom_range(0, 3)); regwr_M = $urandom_range(0, 1);
      memrd_M = $urandom_range(0, 3) == 0;
      waddr_W = 5'($urandom_range(0, 3)); reg_wrW = $urandom_range(0, 1);
      ex_busy = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 11) == 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
